// File: rtl/mips_register_file_pkg.sv
// ============================================================================
//  Module      : mips_register_file_pkg
//  Description : Shared definitions for the MIPS general-purpose register
//                file. The register address width is shared with the ID stage
//                so that both decode the same rs/rt/rd field width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_register_file_pkg;

    // Register address width shared by the ID stage and the register file.
    localparam int REGADDR_WIDTH = 5;

    // Architectural data width of a general-purpose register.
    localparam int REGDATA_WIDTH = 32;

    // Source selected by a read port for the current cycle.
    typedef enum logic [1:0] {
        RD_SRC_ZERO    = 2'd0,  // address 0: hardwired zero
        RD_SRC_BYPASS  = 2'd1,  // same-cycle write forwarded to the reader
        RD_SRC_STORAGE = 2'd2   // value held in the register array
    } rd_src_e;

    // Chooses where a read port takes its data from. Zero detection is done on
    // the address, so register 0 never forwards write data even when the WB
    // stage presents address 0 (its "no write" encoding). The bypass is
    // suppressed during reset because the pending write is going to be lost.
    function automatic rd_src_e read_source(
        input logic [REGADDR_WIDTH-1:0] rd_addr,
        input logic [REGADDR_WIDTH-1:0] wr_addr,
        input logic                     in_reset
    );
        rd_src_e src;
        if (rd_addr == '0) begin
            src = RD_SRC_ZERO;
        end else if (!in_reset && (rd_addr == wr_addr)) begin
            src = RD_SRC_BYPASS;
        end else begin
            src = RD_SRC_STORAGE;
        end
        return src;
    endfunction

endpackage : mips_register_file_pkg

`default_nettype wire

// File: rtl/mips_register_file.sv
// ============================================================================
//  Module      : mips_register_file
//  Description : 32 x 32-bit MIPS general-purpose register file, register 0
//                hardwired to zero. Two combinational read ports (rs, rt) and
//                one write port driven by WB. Writing address 0 means "no
//                write". A same-cycle write-to-read bypass removes the WB->ID
//                hazard.
//
//  Ports:
//    clk         in   1           rising-edge clock
//    rst         in   1           synchronous active-high reset
//    read1_addr  in   ADDR_WIDTH  read port 1 address (rs)
//    read2_addr  in   ADDR_WIDTH  read port 2 address (rt)
//    write_addr  in   ADDR_WIDTH  write address, 0 = no write
//    data_in     in   DATA_WIDTH  write data
//    data_out1   out  DATA_WIDTH  read port 1 data (combinational)
//    data_out2   out  DATA_WIDTH  read port 2 data (combinational)
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_register_file
    import mips_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = REGDATA_WIDTH,
    parameter int ADDR_WIDTH = REGADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // ------------------------------------------------------------------------
    // Storage. Entry 0 exists only to keep the array index range aligned with
    // the address; it is held at zero and never selected by the read muxes.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_addr != '0) begin
            regs_d[write_addr] = data_in;
        end
        regs_d[0] = '0;
    end

    // Reset takes priority: a write presented in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: identical zero / bypass / storage mux per port.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_rd_addr [2];
    logic [DATA_WIDTH-1:0] w_rd_data [2];

    assign w_rd_addr[0] = read1_addr;
    assign w_rd_addr[1] = read2_addr;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_read_port
            rd_src_e w_src;

            always_comb begin
                w_src        = read_source(w_rd_addr[p], write_addr, rst);
                w_rd_data[p] = '0;
                case (w_src)
                    RD_SRC_ZERO:    w_rd_data[p] = '0;
                    RD_SRC_BYPASS:  w_rd_data[p] = data_in;
                    RD_SRC_STORAGE: w_rd_data[p] = regs_q[w_rd_addr[p]];
                    default:        w_rd_data[p] = '0;
                endcase
            end
        end
    endgenerate

    assign data_out1 = w_rd_data[0];
    assign data_out2 = w_rd_data[1];

endmodule : mips_register_file

`default_nettype wire

// File: tb/tb_mips_register_file.sv
// ============================================================================
//  Module      : tb_mips_register_file
//  Description : Directed self-checking bench for mips_register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] read1_addr;
    logic [AW-1:0] read2_addr;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out1;
    logic [DW-1:0] data_out2;

    int n_asserts = 0;
    int n_fail    = 0;

    mips_register_file #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read1_addr (read1_addr),
        .read2_addr (read2_addr),
        .write_addr (write_addr),
        .data_in    (data_in),
        .data_out1  (data_out1),
        .data_out2  (data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs
    // sampled 1 time unit after it, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sweep_val(input int i);
        logic [DW-1:0] v;
        v = 32'h0101_0101 * i;
        return v;
    endfunction

    initial begin
        rst        = 1'b1;
        read1_addr = '0;
        read2_addr = '0;
        write_addr = '0;
        data_in    = '0;

        // ---- Reset: one edge, then sweep all addresses ----
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read1_addr = AW'(i);
            read2_addr = AW'(31 - i);
            #1;
            check("reset_rd1", data_out1, 32'h0);
            check("reset_rd2", data_out2, 32'h0);
        end

        // ---- Basic write/read ----
        write_addr = 5'd5;
        data_in    = 32'hDEAD_BEEF;
        read1_addr = 5'd5;
        read2_addr = 5'd6;
        #1;
        check("basic_bypass_rd1", data_out1, 32'hDEAD_BEEF);
        check("basic_bypass_rd2", data_out2, 32'h0);
        step();
        write_addr = 5'd0;
        data_in    = 32'h0;
        #1;
        check("basic_store_rd1", data_out1, 32'hDEAD_BEEF);
        check("basic_store_rd2", data_out2, 32'h0);

        // ---- Zero register ----
        write_addr = 5'd0;
        data_in    = 32'h1234_5678;
        read1_addr = 5'd0;
        read2_addr = 5'd5;
        #1;
        check("zero_same_cycle", data_out1, 32'h0);
        check("zero_other_port", data_out2, 32'hDEAD_BEEF);
        step();
        check("zero_next_cycle", data_out1, 32'h0);

        // ---- Bypass on both ports ----
        write_addr = 5'd7;
        data_in    = 32'h0000_0001;
        step();
        write_addr = 5'd7;
        data_in    = 32'hCAFE_F00D;
        read1_addr = 5'd7;
        read2_addr = 5'd7;
        #1;
        check("bypass_pre_rd1", data_out1, 32'hCAFE_F00D);
        check("bypass_pre_rd2", data_out2, 32'hCAFE_F00D);
        step();
        write_addr = 5'd0;
        data_in    = 32'h0;
        #1;
        check("bypass_post_rd1", data_out1, 32'hCAFE_F00D);
        check("bypass_post_rd2", data_out2, 32'hCAFE_F00D);

        // ---- Reset versus write ----
        write_addr = 5'd3;
        data_in    = 32'hAAAA_5555;
        step();
        rst        = 1'b1;
        write_addr = 5'd3;
        data_in    = 32'hFFFF_FFFF;
        read1_addr = 5'd3;
        read2_addr = 5'd5;
        #1;
        check("rstwr_during_rd1", data_out1, 32'hAAAA_5555);
        check("rstwr_during_rd2", data_out2, 32'hDEAD_BEEF);
        step();
        rst        = 1'b0;
        write_addr = 5'd0;
        data_in    = 32'h0;
        #1;
        check("rstwr_after_rd1", data_out1, 32'h0);
        check("rstwr_after_rd2", data_out2, 32'h0);

        // First write after reset behaves normally
        write_addr = 5'd3;
        data_in    = 32'h0000_0055;
        step();
        write_addr = 5'd0;
        data_in    = 32'h0;
        #1;
        check("post_rst_write", data_out1, 32'h0000_0055);

        // ---- Full sweep ----
        for (int i = 1; i < 32; i++) begin
            write_addr = AW'(i);
            data_in    = sweep_val(i);
            step();
        end
        write_addr = 5'd0;
        data_in    = 32'h0;
        for (int i = 0; i < 32; i++) begin
            read1_addr = AW'(i);
            read2_addr = AW'(31 - i);
            #1;
            check("sweep_rd1", data_out1, sweep_val(i));
            check("sweep_rd2", data_out2, sweep_val(31 - i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule : tb_mips_register_file

`default_nettype wire
